ex_muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide engine in EX; consumes EX_inst/EX_rs1_val/EX_rs2_val from the ID->EX latch.

---
 rtl/ex_muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage. It uses radix-2 shift-add multiply and restoring divide.
// Define MULDIV_DIV_EN to build the divider and the DIV/DIVU/REM/REMU decode; without it only the MUL* ops exist.
module ex_muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     ex_inst,
    input  logic [XLEN-1:0] ex_rs1_val,
    input  logic [XLEN-1:0] ex_rs2_val,
    input  logic            flush,
    output logic            is_muldiv,
    output logic            md_stall,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    state_t            state;
    logic [CNT_W-1:0]  counter;
    logic [XLEN-1:0]   acc_hi;
    logic [XLEN-1:0]   acc_lo;
    logic [XLEN-1:0]   opnd_b;
    logic [2:0]        op;
    logic              sign1;
    logic              sign2;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic              unused_inst_bits;

    assign opcode           = ex_inst[6:0];
    assign funct3           = ex_inst[14:12];
    assign funct7           = ex_inst[31:25];
    assign unused_inst_bits = ^{ex_inst[24:15], ex_inst[11:7]};

`ifdef MULDIV_DIV_EN
    assign is_muldiv = (opcode == 7'b0110011) && (funct7 == 7'b0000001);
`else
    assign is_muldiv = (opcode == 7'b0110011) && (funct7 == 7'b0000001) && !funct3[2];
`endif

    assign md_stall = ((state == IDLE) && is_muldiv) || (state == BUSY);

    logic            rs1_signed;
    logic            rs2_signed;
    logic            s1_in;
    logic            s2_in;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            special;
    logic [XLEN-1:0] special_val;

    always_comb begin
        rs1_signed  = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3[2] && !funct3[0]);
        rs2_signed  = (funct3 == 3'd1) || (funct3[2] && !funct3[0]);
        s1_in       = rs1_signed && ex_rs1_val[XLEN-1];
        s2_in       = rs2_signed && ex_rs2_val[XLEN-1];
        mag1        = s1_in ? -ex_rs1_val : ex_rs1_val;
        mag2        = s2_in ? -ex_rs2_val : ex_rs2_val;
        special     = 1'b0;
        special_val = '0;
`ifdef MULDIV_DIV_EN
        // Divide-by-zero and signed overflow bypass the iterative datapath entirely.
        if (funct3[2]) begin
            if (ex_rs2_val == '0) begin
                special     = 1'b1;
                special_val = funct3[1] ? ex_rs1_val : '1;
            end else if (!funct3[0] && (ex_rs1_val == {1'b1, {(XLEN-1){1'b0}}})
                         && (ex_rs2_val == '1)) begin
                special     = 1'b1;
                special_val = funct3[1] ? '0 : ex_rs1_val;
            end
        end
`endif
    end

    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   nxt_hi;
    logic [XLEN-1:0]   nxt_lo;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   final_val;
`ifdef MULDIV_DIV_EN
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
`endif

    // acc_hi:acc_lo holds the partial product or the remainder:quotient pair; opnd_b is the multiplicand or divisor.
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
        nxt_hi  = mul_sum[XLEN:1];
        nxt_lo  = {mul_sum[0], acc_lo[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_b};
        if (op[2]) begin
            nxt_hi = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            nxt_lo = {acc_lo[XLEN-2:0], !div_diff[XLEN]};
        end
`endif
        prod      = {nxt_hi, nxt_lo};
        prod_fix  = (sign1 ^ sign2) ? -prod : prod;
        final_val = (op == 3'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
        quo_fix = (sign1 ^ sign2) ? -nxt_lo : nxt_lo;
        rem_fix = sign1 ? -nxt_hi : nxt_hi;
        if (op[2]) begin
            final_val = op[1] ? rem_fix : quo_fix;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            counter      <= '0;
            acc_hi       <= '0;
            acc_lo       <= '0;
            opnd_b       <= '0;
            op           <= '0;
            sign1        <= 1'b0;
            sign2        <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (is_muldiv && !flush) begin
                        op      <= funct3;
                        sign1   <= s1_in;
                        sign2   <= s2_in;
                        counter <= '0;
                        acc_hi  <= '0;
                        if (special) begin
                            result       <= special_val;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end else begin
                            acc_lo <= funct3[2] ? mag1 : mag2;
                            opnd_b <= funct3[2] ? mag2 : mag1;
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc_hi  <= nxt_hi;
                        acc_lo  <= nxt_lo;
                        counter <= counter + 1'b1;
                        if (counter == LAST_ITER) begin
                            result       <= final_val;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit. It applies a directed vector table, randomized ops checked against an arithmetic
// reference, and hand-written flush, reset and back-to-back sequences. Divide coverage follows MULDIV_DIV_EN.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ex_inst;
    logic [31:0] ex_rs1_val;
    logic [31:0] ex_rs2_val;
    logic        flush;
    logic        is_muldiv;
    logic        md_stall;
    logic        result_valid;
    logic [31:0] result;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_inst      (ex_inst),
        .ex_rs1_val   (ex_rs1_val),
        .ex_rs2_val   (ex_rs2_val),
        .flush        (flush),
        .is_muldiv    (is_muldiv),
        .md_stall     (md_stall),
        .result_valid (result_valid),
        .result       (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int unsigned stalls;
    } vec_t;

    function automatic logic [31:0] mk_inst(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // Reference: plain 64-bit integer arithmetic with RISC-V corner-case rules.
    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        logic [63:0]     t;
        case (f3)
            3'd0: begin t = ua * ub; return t[31:0]; end
            3'd1: begin t = sa * sb; return t[63:32]; end
            3'd2: begin t = sa * longint'(ub); return t[63:32]; end
            3'd3: begin t = ua * ub; return t[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; t = sa / sb; return t[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a; t = sa % sb; return t[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int unsigned ref_stalls(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] edges [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        case ($urandom_range(0, 3))
            0: return edges[$urandom_range(0, 4)];
            1: return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called while the unit is IDLE; applies the op now and returns 1ns after the DONE edge.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int unsigned exp_stalls);
        int unsigned stalls = 0;
        ex_inst    = mk_inst(f3);
        ex_rs1_val = a;
        ex_rs2_val = b;
        #1;
        while (md_stall && stalls < 200) begin
            stalls++;
            @(posedge clk);
            #1;
        end
        check({name, " stall_cycles"}, 64'(stalls), 64'(exp_stalls));
        check({name, " result_valid"}, 64'(result_valid), 64'd1);
        check({name, " result"}, 64'(result), 64'(exp));
        check({name, " done_stall"}, 64'(md_stall), 64'd0);
    endtask

    // Moves to the cycle after DONE with a NOP in EX and checks that the result holds.
    task automatic after_done(input string name, input logic [31:0] exp);
        @(posedge clk);
        #1;
        ex_inst = NOP;
        #1;
        check({name, " valid_drop"}, 64'(result_valid), 64'd0);
        check({name, " result_hold"}, 64'(result), 64'(exp));
    endtask

    task automatic watch_no_valid(input string name, input int unsigned cycles, input logic [31:0] held);
        int unsigned seen = 0;
        for (int unsigned i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (result_valid) seen++;
        end
        check({name, " no_valid"}, 64'(seen), 64'd0);
        check({name, " result_kept"}, 64'(result), 64'(held));
    endtask

    vec_t        vecs [$];
    logic [31:0] last;
    logic [2:0]  rf3;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rexp;

    initial begin
        vecs.push_back('{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
        vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33});
        vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33});
        vecs.push_back('{3'd0, 32'h1234_5678, 32'h0,         32'h0,         33});
`ifdef MULDIV_DIV_EN
        vecs.push_back('{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{3'd7, 32'd5,         32'd0,         32'd5,         1});
        vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1});
        vecs.push_back('{3'd4, 32'd9,         32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33});
        vecs.push_back('{3'd5, 32'hFFFF_FFFF, 32'd10,        32'h1999_9999, 33});
        vecs.push_back('{3'd7, 32'hFFFF_FFFF, 32'd10,        32'd5,         33});
`endif

        rst_n      = 1'b0;
        ex_inst    = 32'h0;
        ex_rs1_val = 32'h0;
        ex_rs2_val = 32'h0;
        flush      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset md_stall", 64'(md_stall), 64'd0);
        check("reset result_valid", 64'(result_valid), 64'd0);
        check("reset result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table.
        for (int i = 0; i < vecs.size(); i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stalls);
            after_done($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Non-M instruction (ADD) is ignored.
        ex_inst = 32'h0020_81B3;
        #1;
        check("add is_muldiv", 64'(is_muldiv), 64'd0);
        check("add md_stall", 64'(md_stall), 64'd0);
        last = result;
        watch_no_valid("add", 3, last);

`ifdef MULDIV_DIV_EN
        // Back-to-back: the REM enters while the unit is IDLE, straight after the DIV's DONE.
        run_op("b2b div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        @(posedge clk);
        #1;
        run_op("b2b rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        after_done("b2b rem", 32'hFFFF_FFFF);
`else
        ex_inst    = mk_inst(3'd4);
        ex_rs1_val = 32'd100;
        ex_rs2_val = 32'd7;
        #1;
        check("nodiv is_muldiv", 64'(is_muldiv), 64'd0);
        check("nodiv md_stall", 64'(md_stall), 64'd0);
        last = result;
        watch_no_valid("nodiv", 4, last);
        ex_inst = NOP;
        // Back-to-back multiplies.
        run_op("b2b mul", 3'd0, 32'd6, 32'd7, 32'd42, 33);
        @(posedge clk);
        #1;
        run_op("b2b mulhu", 3'd3, 32'h8000_0000, 32'd4, 32'd2, 33);
        after_done("b2b mulhu", 32'd2);
`endif

        // Randomized ops against the reference model.
        for (int i = 0; i < 60; i++) begin
`ifdef MULDIV_DIV_EN
            rf3 = 3'($urandom_range(0, 7));
`else
            rf3 = 3'($urandom_range(0, 3));
`endif
            ra   = pick_operand();
            rb   = pick_operand();
            rexp = ref_md(rf3, ra, rb);
            run_op($sformatf("rnd%0d f3=%0d a=%h b=%h", i, rf3, ra, rb), rf3, ra, rb, rexp,
                   ref_stalls(rf3, ra, rb));
            after_done($sformatf("rnd%0d", i), rexp);
        end

        // Flush on the 10th BUSY cycle.
        last       = result;
        ex_inst    = mk_inst(3'd0);
        ex_rs1_val = 32'd1234;
        ex_rs2_val = 32'd5678;
        repeat (10) @(posedge clk);
        #1;
        check("flush busy_stall", 64'(md_stall), 64'd1);
        flush   = 1'b1;
        ex_inst = NOP;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush stall_drop", 64'(md_stall), 64'd0);
        watch_no_valid("flush", 40, last);

        // Flush while IDLE suppresses the start.
        ex_inst = mk_inst(3'd3);
        flush   = 1'b1;
        @(posedge clk);
        #1;
        flush   = 1'b0;
        ex_inst = NOP;
        #1;
        check("idle_flush stall", 64'(md_stall), 64'd0);
        watch_no_valid("idle_flush", 40, last);

        // Asynchronous reset in the middle of BUSY, then the unit works again.
        run_op("pre_reset", 3'd0, 32'd3, 32'd5, 32'd15, 33);
        after_done("pre_reset", 32'd15);
        ex_inst    = mk_inst(3'd0);
        ex_rs1_val = 32'd11;
        ex_rs2_val = 32'd13;
        repeat (5) @(posedge clk);
        #2;
        rst_n   = 1'b0;
        ex_inst = NOP;
        #1;
        check("midreset md_stall", 64'(md_stall), 64'd0);
        check("midreset result_valid", 64'(result_valid), 64'd0);
        check("midreset result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("post_reset", 3'd0, 32'd11, 32'd13, 32'd143, 33);
        after_done("post_reset", 32'd143);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
